// File: rtl/sample_drain.sv
// Pops one posedge/negedge word pair from the sampler FIFOs and streams it out
// as a 9-byte tagged record (header, posedge word LSB first, negedge word LSB first).
module sample_drain #(
  parameter logic [3:0] HEADER_TAG  = 4'hA,
  parameter int         COUNT_WIDTH = 16
) (
  input  logic                   system_clock,
  input  logic                   clear,
  input  logic                   enable,
  input  logic [31:0]            sample_in,
  input  logic                   posedge_empty,
  input  logic                   negedge_empty,
  input  logic                   posedge_full,
  input  logic                   negedge_full,
  output logic                   posedge_read_enable,
  output logic                   negedge_read_enable,
  output logic [7:0]             byte_out,
  output logic                   byte_valid,
  input  logic                   byte_ready,
  output logic                   overflow,
  output logic                   busy,
  output logic [COUNT_WIDTH-1:0] record_count
);

  // Byte stream: a byte transfers on a cycle where byte_valid & byte_ready;
  // byte_out/byte_valid are registered and held unchanged until that happens.

  typedef enum logic [2:0] {IDLE, RD_POS, RD_NEG, CAP_NEG, SEND} state_t;

  state_t                 state_q;
  logic [31:0]            pos_q, neg_q;
  logic [3:0]             idx_q;
  logic [2:0]             seq_q;
  logic                   ovf_q, ovf_d;
  logic [COUNT_WIDTH-1:0] cnt_q;
  logic                   pos_re_q, neg_re_q, valid_q, busy_q;
  logic [7:0]             byte_q;
  logic                   full_seen, hs;

  function automatic logic [7:0] pick(input logic [3:0] idx, input logic [31:0] p,
                                      input logic [31:0] n);
    logic [7:0] b;
    b = 8'h00;
    case (idx)
      4'd1: b = p[7:0];
      4'd2: b = p[15:8];
      4'd3: b = p[23:16];
      4'd4: b = p[31:24];
      4'd5: b = n[7:0];
      4'd6: b = n[15:8];
      4'd7: b = n[23:16];
      4'd8: b = n[31:24];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // A full seen in the header handshake cycle survives the clear.
  always_comb begin
    full_seen = posedge_full | negedge_full;
    hs        = valid_q & byte_ready;
    ovf_d     = ovf_q | full_seen;
    if (state_q == SEND && idx_q == 4'd0 && hs) ovf_d = full_seen;
  end

  always_ff @(posedge system_clock or posedge clear) begin
    if (clear) begin
      state_q  <= IDLE;
      pos_q    <= '0;
      neg_q    <= '0;
      idx_q    <= '0;
      seq_q    <= '0;
      ovf_q    <= 1'b0;
      cnt_q    <= '0;
      pos_re_q <= 1'b0;
      neg_re_q <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      byte_q   <= 8'h00;
    end else begin
      ovf_q    <= ovf_d;
      pos_re_q <= 1'b0;
      neg_re_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (enable && !posedge_empty && !negedge_empty) begin
            state_q  <= RD_POS;
            pos_re_q <= 1'b1;
            busy_q   <= 1'b1;
          end
        end
        RD_POS: begin
          state_q  <= RD_NEG;
          neg_re_q <= 1'b1;
        end
        RD_NEG: begin
          pos_q   <= sample_in;
          state_q <= CAP_NEG;
        end
        CAP_NEG: begin
          // Header shows the flag as it stands when the record goes out.
          neg_q   <= sample_in;
          idx_q   <= 4'd0;
          byte_q  <= {HEADER_TAG, seq_q, ovf_d};
          valid_q <= 1'b1;
          state_q <= SEND;
        end
        SEND: begin
          if (hs) begin
            if (idx_q == 4'd8) begin
              seq_q   <= seq_q + 3'd1;
              cnt_q   <= cnt_q + COUNT_WIDTH'(1);
              valid_q <= 1'b0;
              byte_q  <= 8'h00;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              idx_q  <= idx_q + 4'd1;
              byte_q <= pick(idx_q + 4'd1, pos_q, neg_q);
            end
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign posedge_read_enable = pos_re_q;
  assign negedge_read_enable = neg_re_q;
  assign byte_out            = byte_q;
  assign byte_valid          = valid_q;
  assign overflow            = ovf_q;
  assign busy                = busy_q;
  assign record_count        = cnt_q;

endmodule

// File: tb/tb_sample_drain.sv
// Bench for sample_drain: FIFO pair model upstream, record-level byte model
// and scoreboard downstream, directed scenarios with literal expectations.
module tb_sample_drain;

  logic        system_clock = 1'b0;
  logic        clear = 1'b1;
  logic        enable = 1'b0;
  logic [31:0] sample_in = 32'h0;
  logic        posedge_empty, negedge_empty;
  logic        posedge_full = 1'b0, negedge_full = 1'b0;
  logic        posedge_read_enable, negedge_read_enable;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        byte_ready = 1'b0;
  logic        overflow, busy;
  logic [15:0] record_count;

  sample_drain dut (
    .system_clock(system_clock), .clear(clear), .enable(enable), .sample_in(sample_in),
    .posedge_empty(posedge_empty), .negedge_empty(negedge_empty),
    .posedge_full(posedge_full), .negedge_full(negedge_full),
    .posedge_read_enable(posedge_read_enable), .negedge_read_enable(negedge_read_enable),
    .byte_out(byte_out), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .overflow(overflow), .busy(busy), .record_count(record_count)
  );

  // ---------------- clock / reset ----------------
  always #5 system_clock = ~system_clock;

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- upstream FIFO model ----------------
  logic [31:0] pos_mem [0:63];
  logic [31:0] neg_mem [0:63];
  int pos_wr = 0, neg_wr = 0, pos_rd = 0, neg_rd = 0;
  assign posedge_empty = (pos_wr == pos_rd);
  assign negedge_empty = (neg_wr == neg_rd);

  always @(posedge system_clock) begin
    if (posedge_read_enable && pos_rd != pos_wr) begin
      sample_in <= pos_mem[pos_rd];
      pos_rd    <= pos_rd + 1;
    end else if (negedge_read_enable && neg_rd != neg_wr) begin
      sample_in <= neg_mem[neg_rd];
      neg_rd    <= neg_rd + 1;
    end
  end

  int rdy_mode = 0;
  int rdy_phase = 0;
  always @(posedge system_clock) begin
    #1;
    if (rdy_mode == 0) byte_ready = 1'b1;
    else begin
      byte_ready = (rdy_phase == 0);
      rdy_phase  = (rdy_phase + 1) % 3;
    end
  end

  // ---------------- scoreboard ----------------
  int total = 0, bad = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  got_b [0:255];
  int          got_n = 0;
  int          pos_pulses = 0, neg_pulses = 0;
  int          midx = 0, mcount = 0;
  logic [2:0]  mseq = 3'd0;
  logic        mflag = 1'b0, hdr_latched = 1'b0, gap_due = 1'b0, prev_pos_re = 1'b0;
  logic [7:0]  hdr_val = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [7:0] model_byte(input int idx);
    logic [31:0] w;
    if (idx == 0) return hdr_val;
    if (idx <= 4) begin
      w = exp_q[0];
      return w[8*(idx-1) +: 8];
    end
    w = exp_q[1];
    return w[8*(idx-5) +: 8];
  endfunction

  always @(negedge system_clock) begin
    logic hs, full;
    if (clear) begin
      midx = 0; mcount = 0; mseq = 3'd0; mflag = 1'b0;
      hdr_latched = 1'b0; gap_due = 1'b0; prev_pos_re = 1'b0;
      exp_q.delete();
      check("reset_valid", {31'b0, byte_valid}, 32'd0);
      check("reset_busy", {31'b0, busy}, 32'd0);
    end else begin
      check("overflow", {31'b0, overflow}, {31'b0, mflag});
      check("record_count", {16'b0, record_count}, mcount & 32'hFFFF);
      if (posedge_read_enable && negedge_read_enable)
        check("re_both", 32'd1, 32'd0);
      if (posedge_read_enable) begin
        pos_pulses++;
        check("pop_pos_empty", {31'b0, posedge_empty}, 32'd0);
      end
      if (negedge_read_enable) begin
        neg_pulses++;
        check("pop_neg_empty", {31'b0, negedge_empty}, 32'd0);
        check("re_order", {31'b0, prev_pos_re}, 32'd1);
      end
      prev_pos_re = posedge_read_enable;
      if (gap_due) begin
        check("idle_gap", {31'b0, byte_valid}, 32'd0);
        gap_due = 1'b0;
      end
      if (byte_valid) begin
        check("busy_send", {31'b0, busy}, 32'd1);
        if (exp_q.size() < 2) check("unexpected_byte", {24'b0, byte_out}, 32'hFFFF_FFFF);
        else begin
          if (midx == 0 && !hdr_latched) begin
            hdr_val = {4'hA, mseq, mflag};
            hdr_latched = 1'b1;
          end
          check("byte_out", {24'b0, byte_out}, {24'b0, model_byte(midx)});
        end
      end
      hs   = byte_valid && byte_ready;
      full = posedge_full | negedge_full;
      if (hs && midx == 0) mflag = full;
      else mflag = mflag | full;
      if (hs) begin
        if (got_n < 256) got_b[got_n] = byte_out;
        got_n++;
        if (midx == 8) begin
          midx = 0; mseq = mseq + 3'd1; mcount++;
          hdr_latched = 1'b0; gap_due = 1'b1;
          if (exp_q.size() >= 2) begin
            void'(exp_q.pop_front());
            void'(exp_q.pop_front());
          end
        end else midx++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge system_clock);
    #1;
  endtask

  task automatic do_reset();
    clear = 1'b1;
    tick(2);
    clear = 1'b0;
    tick(1);
  endtask

  task automatic load_pos(input logic [31:0] w);
    pos_mem[pos_wr] = w; pos_wr++; exp_q.push_back(w);
  endtask

  task automatic load_neg(input logic [31:0] w);
    neg_mem[neg_wr] = w; neg_wr++; exp_q.push_back(w);
  endtask

  task automatic load_pair(input logic [31:0] p, input logic [31:0] n);
    load_pos(p);
    load_neg(n);
  endtask

  task automatic wait_records(input int n);
    int cyc = 0;
    while (mcount < n && cyc < 600) begin
      tick(1);
      cyc++;
    end
    check("record_timeout", mcount, n);
    tick(2);
  endtask

  task automatic wait_idx(input int n);
    int cyc = 0;
    while (midx != n && cyc < 200) begin
      tick(1);
      cyc++;
    end
    check("idx_timeout", midx, n);
  endtask

  task automatic check_record(input string name, input int base, input logic [7:0] hdr,
                              input logic [31:0] p, input logic [31:0] n);
    logic [7:0] e [0:8];
    e[0] = hdr;
    for (int i = 0; i < 4; i++) begin
      e[1+i] = p[8*i +: 8];
      e[5+i] = n[8*i +: 8];
    end
    for (int i = 0; i < 9; i++) check(name, {24'b0, got_b[base+i]}, {24'b0, e[i]});
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int base, pp, np;
    logic [7:0] single_bytes [0:8];
    single_bytes = '{8'hA0, 8'h44, 8'h33, 8'h22, 8'h11, 8'h88, 8'h77, 8'h66, 8'h55};

    @(negedge system_clock);
    check("rst_byte_out", {24'b0, byte_out}, 32'h0);
    check("rst_overflow", {31'b0, overflow}, 32'd0);
    check("rst_count", {16'b0, record_count}, 32'd0);
    check("rst_re", {30'b0, posedge_read_enable, negedge_read_enable}, 32'd0);
    tick(1);
    clear = 1'b0;
    enable = 1'b1;
    tick(2);

    // Single pair
    base = got_n; pp = pos_pulses; np = neg_pulses;
    load_pair(32'h11223344, 32'h55667788);
    wait_records(1);
    for (int i = 0; i < 9; i++)
      check("single_byte", {24'b0, got_b[base+i]}, {24'b0, single_bytes[i]});
    check("single_count", {16'b0, record_count}, 32'd1);
    check("single_pos_pops", pos_pulses - pp, 32'd1);
    check("single_neg_pops", neg_pulses - np, 32'd1);

    // Backpressure
    do_reset();
    rdy_mode = 1;
    base = got_n; pp = pos_pulses; np = neg_pulses;
    load_pair(32'h11223344, 32'h55667788);
    wait_records(1);
    for (int i = 0; i < 9; i++)
      check("bp_byte", {24'b0, got_b[base+i]}, {24'b0, single_bytes[i]});
    check("bp_pos_pops", pos_pulses - pp, 32'd1);
    check("bp_neg_pops", neg_pulses - np, 32'd1);
    rdy_mode = 0;

    // Overflow
    do_reset();
    posedge_full = 1'b1;
    tick(1);
    posedge_full = 1'b0;
    tick(2);
    check("ovf_set", {31'b0, overflow}, 32'd1);
    base = got_n;
    load_pair(32'hDEADBEEF, 32'h01020304);
    wait_idx(1);
    check("ovf_cleared", {31'b0, overflow}, 32'd0);
    wait_records(1);
    check_record("ovf_rec1", base, 8'hA1, 32'hDEADBEEF, 32'h01020304);
    base = got_n;
    load_pair(32'hA5A5A5A5, 32'h5A5A5A5A);
    wait_records(2);
    check_record("ovf_rec2", base, 8'hA2, 32'hA5A5A5A5, 32'h5A5A5A5A);

    // Sequence wrap, back to back
    do_reset();
    base = got_n;
    for (int i = 0; i < 9; i++)
      load_pair(32'h1000_0000 + i, 32'h2000_0000 + 32'(i * 3));
    wait_records(9);
    for (int i = 0; i < 9; i++)
      check("wrap_hdr", {24'b0, got_b[base+9*i]}, {24'b0, 8'hA0 + 8'((i % 8) * 2)});
    check("wrap_count", {16'b0, record_count}, 32'd9);

    // Imbalance and enable
    do_reset();
    base = got_n; pp = pos_pulses; np = neg_pulses;
    load_pos(32'hCAFE0001);
    tick(10);
    check("imb_pops", (pos_pulses - pp) + (neg_pulses - np), 32'd0);
    check("imb_busy", {31'b0, busy}, 32'd0);
    enable = 1'b0;
    load_neg(32'hBEEF0002);
    tick(10);
    check("dis_pops", (pos_pulses - pp) + (neg_pulses - np), 32'd0);
    check("dis_busy", {31'b0, busy}, 32'd0);
    enable = 1'b1;
    wait_idx(2);
    enable = 1'b0;
    wait_records(1);
    check_record("en_drop", base, 8'hA0, 32'hCAFE0001, 32'hBEEF0002);
    enable = 1'b1;

    // Reset mid-record
    do_reset();
    load_pair(32'h99AABBCC, 32'hDDEEFF00);
    wait_idx(3);
    clear = 1'b1;
    #1;
    check("clr_valid", {31'b0, byte_valid}, 32'd0);
    check("clr_busy", {31'b0, busy}, 32'd0);
    check("clr_count", {16'b0, record_count}, 32'd0);
    tick(2);
    clear = 1'b0;
    base = got_n; pp = pos_pulses; np = neg_pulses;
    tick(20);
    check("post_clr_bytes", got_n - base, 32'd0);
    check("post_clr_pops", (pos_pulses - pp) + (neg_pulses - np), 32'd0);
    check("post_clr_valid", {31'b0, byte_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
